reg8file_ctrl: RTL

Write-port controller for the 8×8 register file (`reg8file`). After reset it clears the file, then sweeps all eight registers to a parameterised initial value. It then shares the single write port between two requesters (A, B) with round-robin arbitration. Read port (`rsel`/`q`) stays with the datapath and is not touched by this block.

---
 rtl/reg8file_ctrl_pkg.sv | 17 +
 rtl/reg8file_ctrl_if.sv | 29 ++
 rtl/reg8file_ctrl_rr_arb2.sv | 36 +++
 rtl/reg8file_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/reg8file_ctrl_pkg.sv
// Shared types and constants for the reg8file write-port controller.
package reg8file_ctrl_pkg;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 8;

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    INIT = 2'd1,
    ARB  = 2'd2
  } state_t;

endpackage

// File: rtl/reg8file_ctrl_if.sv
// Requester and register-file write-port signals of the controller.
interface reg8file_ctrl_if;
  import reg8file_ctrl_pkg::*;

  logic          a_req;
  logic [AW-1:0] a_wsel;
  logic [DW-1:0] a_d;
  logic          a_gnt;
  logic          b_req;
  logic [AW-1:0] b_wsel;
  logic [DW-1:0] b_d;
  logic          b_gnt;
  logic          busy;
  logic          rf_clr;
  logic          rf_en;
  logic [AW-1:0] rf_wsel;
  logic [DW-1:0] rf_d;

  modport master (
    output a_req, a_wsel, a_d, b_req, b_wsel, b_d,
    input  a_gnt, b_gnt, busy, rf_clr, rf_en, rf_wsel, rf_d
  );

  modport slave (
    input  a_req, a_wsel, a_d, b_req, b_wsel, b_d,
    output a_gnt, b_gnt, busy, rf_clr, rf_en, rf_wsel, rf_d
  );

endinterface

// File: rtl/reg8file_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, priority flips to
// the loser after every grant.
module rr_arb2
  import reg8file_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_reg;

  always_comb begin
    gnt = 2'b00;
    if (clr_n && en) begin
      if (req[0] && (!req[1] || prio_reg == PRIO_A)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      prio_reg <= PRIO_A;
    end else if (gnt[0]) begin
      prio_reg <= PRIO_B;
    end else if (gnt[1]) begin
      prio_reg <= PRIO_A;
    end
  end

endmodule

// File: rtl/reg8file_ctrl.sv
// Write-port controller for reg8file: clear, init sweep, then round-robin
// sharing of the single write port between requesters A and B.
module reg8file_ctrl
  import reg8file_ctrl_pkg::*;
#(
  parameter logic [DW-1:0] INIT_VAL = 8'h00
) (
  input  logic            clk,
  input  logic            clr_n,
  reg8file_ctrl_if.slave  bus
);

  localparam logic [1:0] ST_CLR  = CLR;
  localparam logic [1:0] ST_INIT = INIT;
  localparam logic [1:0] ST_ARB  = ARB;

  logic [1:0]    state_reg;
  logic [AW-1:0] cnt_reg;
  logic [1:0]    gnt;
  logic          arb_en;

  assign arb_en = (state_reg == ST_ARB);

  rr_arb2 u_arb (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (arb_en),
    .req   ({bus.b_req, bus.a_req}),
    .gnt   (gnt)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_reg <= ST_CLR;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_CLR: begin
          state_reg <= ST_INIT;
          cnt_reg   <= '0;
        end
        ST_INIT: begin
          cnt_reg <= cnt_reg + 3'd1;
          if (cnt_reg == AW'(NREG - 1)) begin
            state_reg <= ST_ARB;
          end
        end
        ST_ARB: begin
          state_reg <= ST_ARB;
        end
        default: begin
          state_reg <= ST_CLR;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Reset low overrides every state so an in-flight grant never reaches the file.
  always_comb begin
    bus.a_gnt   = 1'b0;
    bus.b_gnt   = 1'b0;
    bus.busy    = 1'b1;
    bus.rf_clr  = 1'b0;
    bus.rf_en   = 1'b0;
    bus.rf_wsel = '0;
    bus.rf_d    = '0;
    if (!clr_n) begin
      bus.rf_clr = 1'b1;
    end else begin
      case (state_reg)
        ST_INIT: begin
          bus.rf_en   = 1'b1;
          bus.rf_wsel = cnt_reg;
          bus.rf_d    = INIT_VAL;
        end
        ST_ARB: begin
          bus.busy  = 1'b0;
          bus.a_gnt = gnt[0];
          bus.b_gnt = gnt[1];
          bus.rf_en = gnt[0] | gnt[1];
          if (gnt[0]) begin
            bus.rf_wsel = bus.a_wsel;
            bus.rf_d    = bus.a_d;
          end else if (gnt[1]) begin
            bus.rf_wsel = bus.b_wsel;
            bus.rf_d    = bus.b_d;
          end
        end
        default: begin
          bus.rf_clr = 1'b1;
        end
      endcase
    end
  end

endmodule
